// File: rtl/io_pkg.sv
// Shared register-map constants for the memory-mapped I/O responder.
// Offsets are addr[3:0] within the 16-word window.
package io_pkg;

    localparam logic [3:0] OFF_NOTE   = 4'd0;
    localparam logic [3:0] OFF_STATUS = 4'd1;
    localparam logic [3:0] OFF_TLOAD  = 4'd2;
    localparam logic [3:0] OFF_TCTRL  = 4'd3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_EXP   = 3;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_AR  = 1;
    localparam int CLR_BIT  = 15;

endpackage

// File: rtl/note_fifo.sv
// Note-word FIFO: power-of-2 depth, naturally wrapping pointers, separate count.
// A push while full succeeds only when a pop frees a slot in the same cycle.
module note_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             pop_ok, push_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;
    assign count   = count_reg;
    // Gate the head so it reads 0 when nothing is queued (including after reset).
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_reg] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop_ok)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (push_ok && !pop_ok)
                count_reg <= count_reg + (AW+1)'(1);
            else if (pop_ok && !push_ok)
                count_reg <= count_reg - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/io_resp.sv
// Memory-mapped I/O responder: note FIFO toward the audio engine plus a
// down-counter timer with sticky expiry; reads are combinational.
module io_resp
    import io_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR  = 16'hF000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic        io_hit,
    output logic [15:0] io_rd_data,
    output logic        note_vld,
    output logic [15:0] note_data,
    input  logic        note_rdy,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [3:0]    offset;
    logic          wr_hit, tload_wr, tctrl_wr, clr_req;
    logic          fifo_empty, fifo_full, fifo_drop;
    logic [CW-1:0] fifo_count;

    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] load_reg;
    logic [1:0]  ctrl_reg;
    logic        exp_reg, exp_next;
    logic        ovf_reg, ovf_next;
    logic        tick, expire;

    assign offset   = addr[3:0];
    assign io_hit   = (addr[15:4] == BASE_ADDR[15:4]) && (re || we);
    assign wr_hit   = io_hit && we;
    assign tload_wr = wr_hit && (offset == OFF_TLOAD);
    assign tctrl_wr = wr_hit && (offset == OFF_TCTRL);
    assign clr_req  = tctrl_wr && wrt_data[CLR_BIT];
    assign note_vld = !fifo_empty;
    assign irq      = exp_reg;

    note_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (wr_hit && (offset == OFF_NOTE)),
        .pop   (note_vld && note_rdy),
        .din   (wrt_data),
        .dout  (note_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count),
        .drop  (fifo_drop)
    );

    // A TLOAD write overrides the counter but does not suppress a 1->0 expiry.
    always_comb begin
        tick     = ctrl_reg[CTRL_EN] && (cnt_reg != 16'd0);
        expire   = tick && (cnt_reg == 16'd1);
        cnt_next = cnt_reg;
        if (tload_wr)
            cnt_next = wrt_data;
        else if (tick)
            cnt_next = cnt_reg - 16'd1;
        else if (ctrl_reg[CTRL_EN] && ctrl_reg[CTRL_AR])
            cnt_next = load_reg;

        exp_next = exp_reg;
        ovf_next = ovf_reg;
        if (clr_req) begin
            exp_next = 1'b0;
            ovf_next = 1'b0;
        end
        if (expire)
            exp_next = 1'b1;
        if (fifo_drop)
            ovf_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            load_reg <= '0;
            ctrl_reg <= '0;
            exp_reg  <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            exp_reg <= exp_next;
            ovf_reg <= ovf_next;
            if (tload_wr)
                load_reg <= wrt_data;
            if (tctrl_wr)
                ctrl_reg <= wrt_data[1:0];
        end
    end

    always_comb begin
        io_rd_data = '0;
        if (io_hit && re) begin
            case (offset)
                OFF_NOTE:   io_rd_data = 16'(fifo_count);
                OFF_STATUS: begin
                    io_rd_data[ST_EMPTY] = fifo_empty;
                    io_rd_data[ST_FULL]  = fifo_full;
                    io_rd_data[ST_OVF]   = ovf_reg;
                    io_rd_data[ST_EXP]   = exp_reg;
                end
                OFF_TLOAD:  io_rd_data = cnt_reg;
                OFF_TCTRL:  io_rd_data = {14'b0, ctrl_reg};
                default:    io_rd_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_io_resp.sv
// Bench for io_resp: constant vector table, hand-written corner sequences and
// random traffic checked against a queue/integer model of the register map.
module tb_io_resp;

    localparam int          DEPTH = 8;
    localparam logic [15:0] BASE  = 16'hF000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [15:0] wrt_data = '0;
    logic        note_rdy = 1'b0;
    logic        io_hit, note_vld, irq;
    logic [15:0] io_rd_data, note_data;

    always #5 clk = ~clk;

    io_resp #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .re         (re),
        .we         (we),
        .wrt_data   (wrt_data),
        .io_hit     (io_hit),
        .io_rd_data (io_rd_data),
        .note_vld   (note_vld),
        .note_data  (note_data),
        .note_rdy   (note_rdy),
        .irq        (irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the FIFO is a queue, the timer plain integers.
    logic [15:0] q[$];
    int  m_cnt, m_load;
    bit  m_en, m_ar, m_exp, m_ovf;

    task automatic m_reset();
        q.delete();
        m_cnt = 0; m_load = 0; m_en = 0; m_ar = 0; m_exp = 0; m_ovf = 0;
    endtask

    function automatic bit m_hit(logic [15:0] a, logic r, logic w);
        return (a[15:4] == BASE[15:4]) && (r || w);
    endfunction

    function automatic logic [15:0] m_rd(logic [15:0] a, logic r, logic w);
        if (!(m_hit(a, r, w) && r)) return 16'h0;
        case (a[3:0])
            4'd0:    return 16'(q.size());
            4'd1:    return {12'b0, m_exp, m_ovf, q.size() == DEPTH, q.size() == 0};
            4'd2:    return 16'(m_cnt);
            4'd3:    return {14'b0, m_ar, m_en};
            default: return 16'h0;
        endcase
    endfunction

    task automatic m_step(input logic [15:0] a, input logic r, input logic w,
                          input logic [15:0] d, input logic rdy);
        bit wr;
        bit pop;
        bit set_exp;
        bit set_ovf;
        int n;
        int nc;
        wr = m_hit(a, r, w) && w;
        n = q.size();
        pop = (n > 0) && rdy;
        set_ovf = 0;
        if (pop) void'(q.pop_front());
        if (wr && a[3:0] == 4'd0) begin
            if (n < DEPTH || pop) q.push_back(d);
            else set_ovf = 1;
        end
        set_exp = m_en && (m_cnt == 1);
        nc = m_cnt;
        if (m_en && m_cnt > 0) nc = m_cnt - 1;
        else if (m_en && m_ar) nc = m_load;
        if (wr && a[3:0] == 4'd2) begin
            m_load = int'(d);
            nc = int'(d);
        end
        if (wr && a[3:0] == 4'd3) begin
            m_en = d[0];
            m_ar = d[1];
            if (d[15]) begin m_exp = 0; m_ovf = 0; end
        end
        m_cnt = nc;
        if (set_exp) m_exp = 1;
        if (set_ovf) m_ovf = 1;
    endtask

    logic        hs, vs;
    logic [15:0] rs, ds;

    // One bus cycle: drive, compare pre-edge outputs with the model, clock.
    task automatic cycle(input logic [15:0] a, input logic r, input logic w,
                         input logic [15:0] d, input logic rdy);
        addr = a; re = r; we = w; wrt_data = d; note_rdy = rdy;
        #2;
        hs = io_hit; rs = io_rd_data; vs = note_vld; ds = note_data;
        chk("io_hit", 16'(io_hit), 16'(m_hit(a, r, w)));
        chk("io_rd_data", io_rd_data, m_rd(a, r, w));
        chk("note_vld", 16'(note_vld), 16'(q.size() > 0));
        chk("note_data", note_data, (q.size() > 0) ? q[0] : 16'h0);
        chk("irq", 16'(irq), 16'(m_exp));
        m_step(a, r, w, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        addr = '0; re = 0; we = 0; wrt_data = '0; note_rdy = 0;
        rst_n = 0;
        m_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic        r, w;
        logic [15:0] d;
        logic        rdy;
        logic        hit;
        logic [15:0] rd;
        logic        vld;
        logic [15:0] nd;
    } vec_t;

    function automatic vec_t mk(logic [15:0] a, logic r, logic w, logic [15:0] d, logic rdy,
                                logic hit, logic [15:0] rd, logic vld, logic [15:0] nd);
        vec_t v;
        v.a = a; v.r = r; v.w = w; v.d = d; v.rdy = rdy;
        v.hit = hit; v.rd = rd; v.vld = vld; v.nd = nd;
        return v;
    endfunction

    vec_t tbl[17];
    logic [15:0] ar_seq[8];

    initial begin
        int edges;
        tbl[0]  = mk(16'hF001, 1, 0, 16'h0000, 0, 1, 16'h0001, 0, 16'h0000);
        tbl[1]  = mk(16'hF000, 0, 1, 16'h1234, 0, 1, 16'h0000, 0, 16'h0000);
        tbl[2]  = mk(16'hF000, 0, 1, 16'h5678, 0, 1, 16'h0000, 1, 16'h1234);
        tbl[3]  = mk(16'hF000, 1, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'h1234);
        tbl[4]  = mk(16'hF001, 1, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'h1234);
        tbl[5]  = mk(16'h1000, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h1234);
        tbl[6]  = mk(16'h1000, 0, 1, 16'hFFFF, 0, 0, 16'h0000, 1, 16'h1234);
        tbl[7]  = mk(16'hF005, 1, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'h1234);
        tbl[8]  = mk(16'hF002, 0, 1, 16'h0007, 0, 1, 16'h0000, 1, 16'h1234);
        tbl[9]  = mk(16'hF002, 1, 0, 16'h0000, 0, 1, 16'h0007, 1, 16'h1234);
        tbl[10] = mk(16'hF003, 1, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'h1234);
        tbl[11] = mk(16'hF000, 1, 1, 16'hAAAA, 0, 1, 16'h0002, 1, 16'h1234);
        tbl[12] = mk(16'hF000, 1, 0, 16'h0000, 1, 1, 16'h0003, 1, 16'h1234);
        tbl[13] = mk(16'hF000, 1, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'h5678);
        tbl[14] = mk(16'hF001, 1, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'h5678);
        tbl[15] = mk(16'hF00F, 1, 1, 16'h0001, 0, 1, 16'h0000, 1, 16'h5678);
        tbl[16] = mk(16'hF000, 1, 0, 16'h0000, 0, 1, 16'h0002, 1, 16'h5678);
        ar_seq = '{16'd3, 16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0};

        // Reset state is observed directly during reset as well.
        #2;
        chk("rst_note_vld", 16'(note_vld), 16'h0);
        chk("rst_note_data", note_data, 16'h0);
        chk("rst_irq", 16'(irq), 16'h0);
        do_reset();

        foreach (tbl[i]) begin
            cycle(tbl[i].a, tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].rdy);
            chk($sformatf("tbl%0d_hit", i), 16'(hs), 16'(tbl[i].hit));
            chk($sformatf("tbl%0d_rd", i), rs, tbl[i].rd);
            chk($sformatf("tbl%0d_vld", i), 16'(vs), 16'(tbl[i].vld));
            chk($sformatf("tbl%0d_data", i), ds, tbl[i].nd);
        end

        // Overflow: a ninth push drops unless a pop happens in the same cycle.
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(BASE, 0, 1, 16'h0100 + 16'(i), 0);
        cycle(BASE, 0, 1, 16'hDEAD, 0);
        cycle(BASE | 16'h1, 1, 0, 16'h0, 0);
        chk("ovf_status", rs, 16'h0006);
        cycle(BASE, 1, 0, 16'h0, 0);
        chk("ovf_count", rs, 16'd8);
        chk("ovf_head", ds, 16'h0100);
        cycle(BASE, 0, 1, 16'hBEEF, 1);
        cycle(BASE, 1, 0, 16'h0, 0);
        chk("full_pp_count", rs, 16'd8);
        chk("full_pp_head", ds, 16'h0101);
        cycle(BASE | 16'h3, 0, 1, 16'h8000, 0);
        cycle(BASE | 16'h1, 1, 0, 16'h0, 0);
        chk("ovf_cleared", rs, 16'h0002);
        for (int i = 0; i < DEPTH; i++) begin
            cycle(16'h0, 0, 0, 16'h0, 1);
            chk($sformatf("drain%0d", i), ds, (i == DEPTH - 1) ? 16'hBEEF : 16'h0101 + 16'(i));
        end
        chk("drained_vld", 16'(note_vld), 16'h0);

        // One-shot timer: irq after exactly five enabled edges, then holds.
        do_reset();
        cycle(BASE | 16'h2, 0, 1, 16'd5, 0);
        cycle(BASE | 16'h3, 0, 1, 16'h0001, 0);
        edges = 0;
        while (!irq && edges < 20) begin
            cycle(BASE | 16'h2, 1, 0, 16'h0, 0);
            edges++;
        end
        chk("edges_to_irq", 16'(edges), 16'd5);
        cycle(BASE | 16'h2, 1, 0, 16'h0, 0);
        chk("oneshot_hold0", rs, 16'h0);
        cycle(BASE | 16'h2, 1, 0, 16'h0, 0);
        chk("oneshot_hold1", rs, 16'h0);
        cycle(BASE | 16'h3, 0, 1, 16'h8001, 0);
        chk("irq_cleared", 16'(irq), 16'h0);

        // Autoreload: 3,2,1,0,3,... with irq set on the 1->0 edge.
        do_reset();
        cycle(BASE | 16'h2, 0, 1, 16'd3, 0);
        cycle(BASE | 16'h3, 0, 1, 16'h0003, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(BASE | 16'h2, 1, 0, 16'h0, 0);
            chk($sformatf("ar_cnt%0d", i), rs, ar_seq[i]);
            if (i == 2) chk("ar_irq", 16'(irq), 16'h1);
        end

        // Asynchronous reset mid-operation.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(BASE, 0, 1, 16'h0A00 + 16'(i), 0);
        cycle(BASE | 16'h2, 0, 1, 16'd20, 0);
        cycle(BASE | 16'h3, 0, 1, 16'h0001, 0);
        cycle(16'h0, 0, 0, 16'h0, 0);
        addr = BASE | 16'h1; re = 1; we = 0; note_rdy = 0;
        #1;
        rst_n = 0;
        m_reset();
        #1;
        chk("arst_vld", 16'(note_vld), 16'h0);
        chk("arst_data", note_data, 16'h0);
        chk("arst_status", io_rd_data, 16'h0001);
        addr = BASE | 16'h2;
        #1;
        chk("arst_tcount", io_rd_data, 16'h0);
        addr = BASE;
        #1;
        chk("arst_fcount", io_rd_data, 16'h0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        cycle(BASE, 1, 0, 16'h0, 0);

        // Random traffic against the model.
        for (int n = 0; n < 800; n++) begin
            logic [15:0] a;
            logic [15:0] d;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel <= 5) a = BASE | 16'($urandom_range(0, 3));
            else if (sel == 6) a = BASE | 16'($urandom_range(4, 15));
            else a = 16'($urandom) & 16'hEFFF;
            d = 16'($urandom);
            if (a[3:0] == 4'd2) d = 16'($urandom_range(0, 6));
            if (a[3:0] == 4'd3) d = {($urandom_range(0, 7) == 0), 13'b0, 2'($urandom_range(0, 3))};
            cycle(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
                  d, ($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
